imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
Memory-side responder for the Addr/Rd/Wr → DataOut/Done/Stall/CacheHit/err request interface used by the fetch and memory stages.
- Serves 16-bit word reads and writes from an internal word array.
- A direct-mapped tag store models hit/miss timing: hits complete in the request cycle, misses stall for a fixed latency.
- Gives pipeline benches a small, deterministic, cycle-exact stand-in for the full memory system.

Parameters:
MEM_AW, 10, word-address width; the array holds 2^MEM_AW 16-bit words, indexed by Addr[MEM_AW:1]. Higher Addr bits are ignored (aliasing).
IDX_W, 3, tag-store index width; 2^IDX_W lines, index = Addr[IDX_W:1], tag = Addr[15:IDX_W+1].
MISS_LAT, 4, cycles from the miss request cycle to Done (≥2).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
Addr  input  16  byte address; must be even
DataIn  input  16  write data
Rd  input  1  read request
Wr  input  1  write request
createdump  input  1  reserved; no functional effect
DataOut  output  16  read data, valid only when Done=1 for a read; otherwise 0
Done  output  1  request complete this cycle
Stall  output  1  responder busy; new requests ignored
CacheHit  output  1  qualifies Done: 1 = hit completion, 0 = miss completion
err  output  1  illegal request, asserted together with Done

Behaviour:
- Reset, sampled on the clk edge:
  - state → IDLE; all tag valid bits cleared; pending op discarded.
  - Word array is not reset.
  - In any cycle where rst=1, all outputs are forced to 0.
- Request = Rd|Wr, sampled only in IDLE.
- Illegal request = request with Addr[0]=1, or Rd&Wr.
  - Same cycle: Done=1, err=1, CacheHit=0, DataOut=0.
  - No array or tag update; state stays IDLE.
- States: IDLE, BUSY, RESP.
- IDLE, legal request at cycle T, hit (valid[idx] & tag match):
  - Cycle T: Done=1, CacheHit=1, Stall=0.
  - Rd: DataOut = array[word] combinationally.
  - Wr: array[word] ← DataIn at the end of T (write-through); DataOut=0.
  - Stays IDLE, so back-to-back hits complete one per cycle.
- IDLE, legal request at cycle T, miss:
  - Cycle T: Done=0, Stall=1.
  - Latch Addr, DataIn, op; load counter = MISS_LAT-2; → BUSY.
- BUSY:
  - Stall=1, Done=0; counter decrements each cycle.
  - When counter = 0, → RESP.
  - Stall is therefore high for cycles T..T+MISS_LAT-1.
  - Rd/Wr/Addr/DataIn changes are ignored; the latched values are used.
- RESP (cycle T+MISS_LAT):
  - Done=1, CacheHit=0, Stall=0.
  - Set valid[idx] and tag[idx] from the latched address; allocation applies to both reads and writes.
  - Latched Wr: array ← latched DataIn at the end of the cycle; DataOut=0.
  - Latched Rd: DataOut = array[latched word].
  - → IDLE. A request present during RESP is ignored; the requester re-presents it in the following cycle.
- Done, err and CacheHit are never asserted in IDLE without a request.
- Done and Stall are never high in the same cycle.
- Conflict: a different tag at the same index evicts the old line, with no writeback needed.
- Aliasing: Addrs that differ only above bit MEM_AW share array words but carry different tags.
- Reset during BUSY or RESP: pending write is lost; the next request to that address misses.

Test Plan:
1. Reset 2 cycles; Wr Addr=0x0010 DataIn=0xBEEF at T → Stall=1 for T..T+3, Done=1 CacheHit=0 at T+4. Then Rd 0x0010 → Done=1 CacheHit=1 DataOut=0xBEEF in the same cycle.
2. After scenario 1: Rd 0x0110 (same index 0, new tag) → 4-cycle miss, DataOut=0x0000 if never written. Then Rd 0x0010 → miss again (evicted), DataOut=0xBEEF.
3. Rd Addr=0x0011, and separately Rd=Wr=1 at Addr=0x0020 → each: Done=1 err=1 DataOut=0 in the request cycle. A following Rd 0x0020 still misses (no allocation).
4. Rd miss at T; rst=1 at T+2 → outputs 0 at T+2, IDLE at T+3. Rd same Addr at T+3 → Stall=1, miss again.
5. Rd miss at 0x0040 (preloaded 0x1234); during BUSY drive Addr=0x0050 Wr=1 DataIn=0xFFFF → Done at T+4 with DataOut=0x1234. Array word at 0x0050 unchanged.
6. Wr 0x0000 DataIn=0xA5A5 (miss then hit-write); Rd 0x0800 (MEM_AW=10 alias) → miss, DataOut=0xA5A5 at T+4.

Source files
------------

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Memory-side responder for the Addr/Rd/Wr -> DataOut/Done/Stall/CacheHit/err
// request interface used by the fetch and memory stages. It gives pipeline
// benches a small, deterministic, cycle-exact stand-in for the memory system.
//
// Behaviour:
//   - 16-bit word reads and writes from an internal array of 2^MEM_AW words,
//     indexed by i_addr[MEM_AW:1]. Higher address bits alias onto the array.
//   - A direct-mapped tag store (2^IDX_W lines) only models timing: a hit
//     completes in the request cycle, a miss stalls and completes MISS_LAT
//     cycles after the request. Every completed miss allocates its line.
//   - Writes go straight to the array (write-through), so eviction needs no
//     writeback.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous, active-high reset; forces all outputs to 0
//   i_addr        byte address, must be even
//   i_data_in     write data
//   i_rd, i_wr    read / write request (both high is illegal)
//   i_createdump  reserved, no functional effect
//   o_data_out    read data while o_done is high for a read, otherwise 0
//   o_done        request complete this cycle
//   o_stall       responder busy, new requests ignored
//   o_cache_hit   qualifies o_done: 1 = hit completion, 0 = miss completion
//   o_err         illegal request, asserted together with o_done
// -----------------------------------------------------------------------------
module imem_responder #(
   parameter int MEM_AW   = 10,
   parameter int IDX_W    = 3,
   parameter int MISS_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_data_in,
   input  logic        i_rd,
   input  logic        i_wr,
   input  logic        i_createdump,
   output logic [15:0] o_data_out,
   output logic        o_done,
   output logic        o_stall,
   output logic        o_cache_hit,
   output logic        o_err
);

   localparam int TAG_W = 15 - IDX_W;        // bits [15:IDX_W+1]
   localparam int LINES = 2 ** IDX_W;
   localparam int WORDS = 2 ** MEM_AW;
   // Counter holds at most MISS_LAT-2.
   localparam int CNT_W = (MISS_LAT > 2) ? $clog2(MISS_LAT - 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [15:1]        r_addr;     // latched miss address (always even)
   logic [15:0]        r_data;     // latched write data
   logic               r_wr;       // latched op: 1 = write, 0 = read
   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag [LINES];
   logic [15:0]        r_mem [WORDS];

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   logic               w_req;
   logic               w_illegal;
   logic [IDX_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [MEM_AW-1:0]  w_word;
   logic               w_hit;
   logic               w_accept;
   logic               w_hit_acc;
   logic               w_miss_acc;
   logic               w_resp;

   logic [IDX_W-1:0]   w_l_idx;
   logic [TAG_W-1:0]   w_l_tag;
   logic [MEM_AW-1:0]  w_l_word;

   logic [MEM_AW-1:0]  w_rd_word;
   logic [15:0]        w_rd_data;
   logic               w_mem_we;
   logic [MEM_AW-1:0]  w_mem_addr;
   logic [15:0]        w_mem_wdata;

   logic               w_unused;

   assign w_req     = i_rd | i_wr;
   assign w_illegal = i_addr[0] | (i_rd & i_wr);

   assign w_idx  = i_addr[IDX_W:1];
   assign w_tag  = i_addr[15:IDX_W+1];
   assign w_word = i_addr[MEM_AW:1];

   assign w_l_idx  = r_addr[IDX_W:1];
   assign w_l_tag  = r_addr[15:IDX_W+1];
   assign w_l_word = r_addr[MEM_AW:1];

   assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   // Requests are only looked at in IDLE and never while reset is applied.
   assign w_accept   = !rst && (r_state == ST_IDLE) && w_req && !w_illegal;
   assign w_hit_acc  = w_accept &&  w_hit;
   assign w_miss_acc = w_accept && !w_hit;
   assign w_resp     = !rst && (r_state == ST_RESP);

   // One array port serves both the hit path (live address) and the miss
   // completion (latched address); the two are mutually exclusive by state.
   assign w_rd_word   = (r_state == ST_RESP) ? w_l_word : w_word;
   assign w_rd_data   = r_mem[w_rd_word];

   assign w_mem_we    = (w_hit_acc && i_wr) || (w_resp && r_wr);
   assign w_mem_addr  = w_resp ? w_l_word : w_word;
   assign w_mem_wdata = w_resp ? r_data   : i_data_in;

   assign w_unused = i_createdump;

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // Hits must complete in the request cycle, so the outputs are decoded
   // from the current state and the live request rather than registered.
   // NOTE: every output gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      o_data_out  = '0;
      o_done      = 1'b0;
      o_stall     = 1'b0;
      o_cache_hit = 1'b0;
      o_err       = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  if (w_illegal) begin
                     o_done = 1'b1;
                     o_err  = 1'b1;
                  end else if (w_hit) begin
                     o_done      = 1'b1;
                     o_cache_hit = 1'b1;
                     if (i_rd) begin
                        o_data_out = w_rd_data;
                     end
                  end else begin
                     o_stall = 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               o_stall = 1'b1;
            end
            ST_RESP: begin
               o_done = 1'b1;
               if (!r_wr) begin
                  o_data_out = w_rd_data;
               end
            end
            default: begin
               o_stall = 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM, valid bits and miss latch
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_valid <= '0;
         r_cnt   <= '0;
         r_wr    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_miss_acc) begin
                  r_state <= ST_BUSY;
                  r_cnt   <= CNT_W'(MISS_LAT - 2);
                  r_addr  <= i_addr[15:1];
                  r_data  <= i_data_in;
                  r_wr    <= i_wr;
               end
            end
            ST_BUSY: begin
               if (r_cnt == '0) begin
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               // Allocate on completion, for reads and writes alike.
               r_valid[w_l_idx] <= 1'b1;
               r_state          <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Tag store and word array
   // ---------------------------------------------------------------------
   // NOTE: tags and array words carry no reset; the cleared valid bits make
   // stale tags harmless, and the array contents must survive reset.
   always_ff @(posedge clk) begin
      if (w_resp) begin
         r_tag[w_l_idx] <= w_l_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // Interface invariants
   // ---------------------------------------------------------------------
   a_done_xor_stall : assert property (@(posedge clk) !(o_done && o_stall));
   a_rst_quiet      : assert property (@(posedge clk)
                         rst |-> !(o_done || o_stall || o_err || o_cache_hit));
   a_err_with_done  : assert property (@(posedge clk) o_err |-> o_done);

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Scoreboard bench for imem_responder. The driver issues requests, asks a
// behavioural model (plain arrays holding the word memory and the tag store)
// what must happen, and queues the expected completion together with the
// cycles in which Stall must be high. A monitor samples the DUT on the
// falling edge and compares against whatever the driver queued.
// -----------------------------------------------------------------------------
module tb_imem_responder;

   localparam int MISS_LAT = 4;
   localparam int NWORDS   = 1024;
   localparam int NLINES   = 8;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic [15:0] din;
   logic        rd;
   logic        wr;
   logic        createdump;
   logic [15:0] dout;
   logic        done;
   logic        stall;
   logic        chit;
   logic        err;

   imem_responder #(
      .MEM_AW   (10),
      .IDX_W    (3),
      .MISS_LAT (MISS_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_addr       (addr),
      .i_data_in    (din),
      .i_rd         (rd),
      .i_wr         (wr),
      .i_createdump (createdump),
      .o_data_out   (dout),
      .o_done       (done),
      .o_stall      (stall),
      .o_cache_hit  (chit),
      .o_err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------
   typedef struct {
      int          done_cyc;
      logic [15:0] data;
      logic        hit;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   bit   stall_exp[int];

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0h expected %0h",
                    name, cyc, act, expv);
   endtask

   // ---------------------------------------------------------------------
   // Reference model: word memory, valid bits and tags per line
   // ---------------------------------------------------------------------
   logic [15:0] m_mem   [NWORDS];
   bit          m_valid [NLINES];
   int          m_tag   [NLINES];

   function automatic int f_idx(input logic [15:0] a);
      return (int'(a) / 2) % NLINES;
   endfunction

   function automatic int f_tag(input logic [15:0] a);
      return int'(a) / (2 * NLINES);
   endfunction

   function automatic int f_word(input logic [15:0] a);
      return (int'(a) / 2) % NWORDS;
   endfunction

   function automatic bit f_legal_miss(input bit r, input bit w,
                                       input logic [15:0] a);
      if (a[0] || (r && w) || !(r || w)) return 1'b0;
      return !(m_valid[f_idx(a)] && m_tag[f_idx(a)] == f_tag(a));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NLINES; i++) m_valid[i] = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   exp_t mon_e;
   bit   mon_due;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_outputs_zero", {12'd0, done, stall, chit, err, dout}, 32'd0);
      end else begin
         mon_due = (exp_q.size() > 0) && (exp_q[0].done_cyc == cyc);
         check("done", done, mon_due);
         check("stall", stall, stall_exp.exists(cyc));
         if (mon_due) begin
            mon_e = exp_q.pop_front();
            check("data_out", dout, mon_e.data);
            check("cache_hit", chit, mon_e.hit);
            check("err", err, mon_e.err);
         end else begin
            check("quiet_outputs", {dout, chit, err}, 32'd0);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------
   bit junk_fixed = 1'b0;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Inputs while the responder is busy; the DUT must ignore all of them.
   task automatic drive_junk();
      if (junk_fixed) begin
         rd   = 1'b0;
         wr   = 1'b1;
         addr = 16'h0050;
         din  = 16'hFFFF;
      end else begin
         rd   = 1'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         addr = 16'($urandom);
         din  = 16'($urandom);
      end
   endtask

   task automatic idle(input int n);
      rd = 1'b0;
      wr = 1'b0;
      for (int i = 0; i < n; i++) begin
         addr = 16'($urandom);
         next_cycle();
      end
   endtask

   // Issue one request at the current cycle and return at the first cycle
   // in which a new request is accepted again.
   task automatic req(input bit r, input bit w, input logic [15:0] a,
                      input logic [15:0] d);
      exp_t e;
      int   t;
      int   ix;
      int   wd;
      t  = cyc;
      rd = r;
      wr = w;
      addr = a;
      din  = d;
      ix = f_idx(a);
      wd = f_word(a);
      if (a[0] || (r && w)) begin
         e.done_cyc = t; e.data = 16'h0; e.hit = 1'b0; e.err = 1'b1;
         exp_q.push_back(e);
         next_cycle();
      end else if (m_valid[ix] && m_tag[ix] == f_tag(a)) begin
         e.done_cyc = t; e.data = r ? m_mem[wd] : 16'h0; e.hit = 1'b1; e.err = 1'b0;
         exp_q.push_back(e);
         if (w) m_mem[wd] = d;
         next_cycle();
      end else begin
         for (int k = 0; k < MISS_LAT; k++) stall_exp[t + k] = 1'b1;
         e.done_cyc = t + MISS_LAT; e.data = r ? m_mem[wd] : 16'h0;
         e.hit = 1'b0; e.err = 1'b0;
         exp_q.push_back(e);
         m_valid[ix] = 1'b1;
         m_tag[ix]   = f_tag(a);
         if (w) m_mem[wd] = d;
         for (int k = 1; k <= MISS_LAT; k++) begin
            next_cycle();
            drive_junk();
         end
         next_cycle();
      end
      rd = 1'b0;
      wr = 1'b0;
   endtask

   // Issue a request known to miss, then assert reset rst_at cycles later
   // (1..MISS_LAT). The pending operation must vanish without a trace.
   task automatic req_abort(input bit r, input bit w, input logic [15:0] a,
                            input logic [15:0] d, input int rst_at);
      int t;
      t  = cyc;
      rd = r;
      wr = w;
      addr = a;
      din  = d;
      for (int k = 0; k < rst_at; k++) stall_exp[t + k] = 1'b1;
      for (int k = 1; k <= rst_at; k++) begin
         next_cycle();
         if (k < rst_at) drive_junk();
         else begin
            rd  = 1'b0;
            wr  = 1'b0;
            rst = 1'b1;
         end
      end
      model_reset();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rd  = 1'b0;
      wr  = 1'b0;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < n; i++) next_cycle();
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      logic [15:0] a;
      logic [15:0] last_a;
      int          kind;
      bit          r;
      bit          w;

      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0; din = 16'h0;
      createdump = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Give every array word a known value through the normal write path.
      for (int i = 0; i < NWORDS; i++) req(1'b0, 1'b1, 16'(2 * i), 16'h0000);
      do_reset(2);

      // Miss-write, then a hit-read of the same word.
      req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
      req(1'b1, 1'b0, 16'h0010, 16'h0);

      // Same index, new tag evicts; the old address then misses again.
      req(1'b1, 1'b0, 16'h0110, 16'h0);
      req(1'b1, 1'b0, 16'h0010, 16'h0);

      // Illegal requests complete at once and allocate nothing.
      req(1'b1, 1'b0, 16'h0011, 16'h0);
      req(1'b1, 1'b1, 16'h0020, 16'h0);
      req(1'b1, 1'b0, 16'h0020, 16'h0);

      // Reset in the middle of a read miss, and in the completion cycle of
      // a write miss.
      req_abort(1'b1, 1'b0, 16'h0030, 16'h0, 2);
      req(1'b1, 1'b0, 16'h0030, 16'h0);
      req_abort(1'b0, 1'b1, 16'h0032, 16'h7777, MISS_LAT);
      req(1'b1, 1'b0, 16'h0032, 16'h0);

      // Inputs changing during BUSY must not disturb the latched read.
      req(1'b0, 1'b1, 16'h0040, 16'h1234);
      req(1'b1, 1'b0, 16'h0050, 16'h0);
      junk_fixed = 1'b1;
      req(1'b1, 1'b0, 16'h0040, 16'h0);
      junk_fixed = 1'b0;
      req(1'b1, 1'b0, 16'h0050, 16'h0);

      // Write miss, write hit, then a read through an aliasing address.
      req(1'b0, 1'b1, 16'h0000, 16'hA5A5);
      req(1'b0, 1'b1, 16'h0000, 16'hA5A5);
      req(1'b1, 1'b0, 16'h0800, 16'h0);

      // Random traffic over a small address pool so hits, conflicts and
      // aliases all occur; occasional resets land inside misses.
      last_a = 16'h0;
      for (int n = 0; n < 500; n++) begin
         kind = $urandom_range(0, 99);
         if (kind < 35) a = last_a;
         else a = 16'(($urandom_range(0, 3) << 11) | ($urandom_range(0, 3) << 4)
                      | ($urandom_range(0, 7) << 1));
         r = 1'($urandom_range(0, 1));
         w = !r;
         if (kind >= 90 && kind < 95) a[0] = 1'b1;
         if (kind >= 95) begin
            r = 1'b1;
            w = 1'b1;
         end
         if (f_legal_miss(r, w, a) && $urandom_range(0, 19) == 0)
            req_abort(r, w, a, 16'($urandom), $urandom_range(1, MISS_LAT));
         else
            req(r, w, a, 16'($urandom));
         last_a = a & 16'hFFFE;
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      idle(MISS_LAT + 2);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
